inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
Streaming RV32I instruction encoder, the inverse of the ID-stage control decoder. It accepts one field-level instruction request per handshake and range-checks the fields. It then packs them into a 32-bit machine word and emits the word with its target instruction-memory address. The block sits in front of the instruction-memory write port and is used by the program loader and by self-test generators to build programs in place.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first emitted word
DEPTH, 1024, maximum number of words emitted before the block reports full (power of two, ≥2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous; restart address counter, drop held word, clear error state
req_valid  input  1  request present
req_ready  output  1  request accepted this cycle when req_valid&&req_ready
req_class  input  4  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JALR, 6 LUI, 7 AUIPC, 8 JAL
req_funct3  input  3  funct3 field
req_alt  input  1  funct7[5] selector (sub/sra/srai)
req_rd  input  5  destination register
req_rs1  input  5  source 1
req_rs2  input  5  source 2
req_imm  input  32  immediate as a full signed/unsigned value (U-type: bits 31:12 used)
out_valid  output  1  encoded word held
out_ready  input  1  downstream accepts
out_inst  output  32  encoded instruction
out_addr  output  32  BASE_ADDR + 4*index
full  output  1  DEPTH words emitted
err  output  1  sticky, an illegal request was consumed
err_cnt  output  8  illegal requests consumed, saturates at 255

Behaviour:
- Reset: out_valid=0, out_inst=0, out_addr=BASE_ADDR, full=0, err=0, err_cnt=0, index=0.
- FSM states:
  - IDLE (no word held)
  - HOLD (out_valid=1)
  - FULL (index==DEPTH)
- FSM transitions:
  - IDLE→HOLD on an accepted legal request.
  - HOLD→HOLD on out_ready with a simultaneous legal accept.
  - HOLD→IDLE on out_ready with no legal accept.
  - After the handshake that emits word DEPTH-1, go to FULL.
  - FULL persists until clear.
- req_ready = !clear && !full_pending && (!out_valid || out_ready). full_pending means index == DEPTH, counting the in-flight word.
- Latency: 1 cycle. A legal accept at edge N gives out_valid with the word at N+1.
- out_inst and out_addr are stable while out_valid=1 and out_ready=0.
- index increments on each out handshake. out_addr of the held word = BASE_ADDR + {index,2'b00}.
- Encoding, opcodes:
  - R 0110011, funct7 = alt ? 0100000 : 0000000
  - I-ALU 0010011, imm[11:0]; for f3=001/101: {alt?0100000:0000000, imm[4:0]}
  - LOAD 0000011
  - STORE 0100011: {imm[11:5], rs2, rs1, f3, imm[4:0]}
  - BRANCH 1100011: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11]}
  - JALR 1100111, f3=000
  - LUI 0110111 and AUIPC 0010111: {imm[31:12], rd}
  - JAL 1101111: {imm[20], imm[10:1], imm[11], imm[19:12], rd}
  - Unused register fields are driven 0.
- Illegal requests. Each is consumed (req_ready honoured), produces no output, sets err, and increments err_cnt with saturation:
  - class >8
  - LOAD f3∈{3,6,7}
  - STORE f3>2
  - BRANCH f3∈{2,3}
  - JALR f3≠0
  - R alt=1 with f3∉{0,5}
  - I-ALU alt=1 with f3≠5
  - BRANCH/JAL with imm[0]=1
- An illegal accept in HOLD with out_ready leaves the FSM in IDLE.
- clear has priority over everything:
  - next cycle out_valid=0, index=0, err=0, err_cnt=0, full=0
  - a held word is discarded
  - no request is accepted while clear=1
- Reset asserted mid-HOLD discards the word immediately (asynchronous).
- Range checks on imm high bits are not performed; truncation is by field slicing only.

Test Plan:
- Encode from reset: addi x1,x0,5 (class1,f3=0,rd=1,imm=5), out_ready=1 → out_inst=0x00500093, out_addr=BASE_ADDR, one cycle after accept.
- Field packing: stream of four requests, back-to-back with out_ready=1 every cycle → one word per cycle, addresses BASE+0/4/8/12.
  - sub x3,x1,x2 → 0x402081B3
  - sw x2,8(x1) → 0x0020A423
  - beq x1,x2,-4 → 0xFE208EE3
  - jal x1,8 → 0x008000EF
- Backpressure: lui x5,0x12345000 with out_ready=0 for 5 cycles → out_valid=1, out_inst=0x123452B7 stable, req_ready=0; a second request is accepted in the same cycle out_ready rises.
- Illegal input: JALR f3=1 followed by BRANCH imm=3 → both consumed, no out_valid, err=1, err_cnt=2; a following legal request is still emitted.
- Full: DEPTH=4, six legal requests → four words emitted, full=1, req_ready=0; clear → full=0, next word at BASE_ADDR.
- Reset during HOLD: rst_n low mid-HOLD → out_valid=0 asynchronously, out_addr=BASE_ADDR.

Source files
------------

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: takes one field-level request per handshake, range-checks it,
// packs the 32-bit machine word and presents it with its instruction-memory address.
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_class,
    input  logic [2:0]  req_funct3,
    input  logic        req_alt,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        full,
    output logic        err,
    output logic [7:0]  err_cnt
);

    // One extra index bit so the counter can reach DEPTH itself.
    localparam int IW  = $clog2(DEPTH) + 1;
    localparam int IW1 = IW + 1;
    localparam logic [IW-1:0] DEPTH_I = IW'(DEPTH);
    localparam logic [IW:0]   DEPTH_P = IW1'(DEPTH);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_FULL = 2'b10
    } state_e;

    function automatic logic is_legal(
        input logic [3:0] cls,
        input logic [2:0] f3,
        input logic       alt,
        input logic       imm0
    );
        logic ok;
        case (cls)
            4'd0:       ok = !alt || (f3 == 3'd0) || (f3 == 3'd5);
            4'd1:       ok = !alt || (f3 == 3'd5);
            4'd2:       ok = !((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
            4'd3:       ok = (f3 <= 3'd2);
            4'd4:       ok = !((f3 == 3'd2) || (f3 == 3'd3)) && !imm0;
            4'd5:       ok = (f3 == 3'd0);
            4'd6, 4'd7: ok = 1'b1;
            4'd8:       ok = !imm0;
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Immediate scrambling follows the RV32I base formats; fields a format lacks stay zero.
    function automatic logic [31:0] encode(
        input logic [3:0]  cls,
        input logic [2:0]  f3,
        input logic        alt,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [6:0]  f7;
        logic [11:0] i12;
        logic [31:0] w;
        f7 = alt ? 7'b0100000 : 7'b0000000;
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
            i12 = {f7, imm[4:0]};
        end else begin
            i12 = imm[11:0];
        end
        case (cls)
            4'd0:    w = {f7, rs2, rs1, f3, rd, OP_R};
            4'd1:    w = {i12, rs1, f3, rd, OP_IALU};
            4'd2:    w = {imm[11:0], rs1, f3, rd, OP_LOAD};
            4'd3:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            4'd4:    w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
            4'd5:    w = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            4'd6:    w = {imm[31:12], rd, OP_LUI};
            4'd7:    w = {imm[31:12], rd, OP_AUIPC};
            4'd8:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] addr_of(input logic [IW-1:0] idx);
        return BASE_ADDR + (32'(idx) * 32'd4);
    endfunction

    state_e        state_q;
    logic [IW-1:0] index_q;
    logic [IW-1:0] index_d;
    logic          out_valid_q;
    logic [31:0]   out_inst_q;
    logic [31:0]   out_addr_q;
    logic          full_q;
    logic          err_q;
    logic [7:0]    err_cnt_q;
    logic [7:0]    err_cnt_d;

    logic [IW:0]   pending_s;
    logic          full_pending_s;
    logic          ready_s;
    logic          accept_s;
    logic          legal_s;
    logic          out_fire_s;
    logic [31:0]   word_s;

    // Handshake qualifiers, word packing and next index / error count.
    always_comb begin
        pending_s      = {1'b0, index_q} + {{IW{1'b0}}, out_valid_q};
        full_pending_s = (pending_s == DEPTH_P);
        ready_s        = !clear && !full_pending_s && (!out_valid_q || out_ready);
        accept_s       = req_valid && ready_s;
        legal_s        = is_legal(req_class, req_funct3, req_alt, req_imm[0]);
        word_s         = encode(req_class, req_funct3, req_alt, req_rd, req_rs1, req_rs2, req_imm);
        out_fire_s     = out_valid_q && out_ready;
        index_d        = index_q + {{(IW-1){1'b0}}, out_fire_s};
        if (accept_s && !legal_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Output FSM: IDLE/HOLD/FULL with registered word, address, full and error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'h0000_0000;
            out_addr_q  <= BASE_ADDR;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else if (clear) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'h0000_0000;
            out_addr_q  <= BASE_ADDR;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            index_q   <= index_d;
            err_cnt_q <= err_cnt_d;
            if (accept_s && !legal_s) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept_s && legal_s) begin
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                        out_inst_q  <= word_s;
                        out_addr_q  <= addr_of(index_d);
                    end
                end
                ST_HOLD: begin
                    if (accept_s && legal_s) begin
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                        out_inst_q  <= word_s;
                        out_addr_q  <= addr_of(index_d);
                    end else if (out_fire_s) begin
                        out_valid_q <= 1'b0;
                        out_addr_q  <= addr_of(index_d);
                        if (index_d == DEPTH_I) begin
                            state_q <= ST_FULL;
                            full_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_FULL: begin
                    state_q <= ST_FULL;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = ready_s;
    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_addr  = out_addr_q;
    assign full      = full_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_inst_encoder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 4;

    typedef struct packed {
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_t;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_class;
    logic [2:0]  req_funct3;
    logic        req_alt;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        full;
    logic        err;
    logic [7:0]  err_cnt;

    inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_class(req_class), .req_funct3(req_funct3), .req_alt(req_alt),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr),
        .full(full), .err(err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];
    logic [31:0] seen_inst [$];
    logic [31:0] seen_addr [$];
    int  widx    = 0;
    int  exp_err = 0;
    bit  rand_rdy = 1'b0;
    int unsigned OPC [0:8] = '{32'h33, 32'h13, 32'h03, 32'h23, 32'h63, 32'h67, 32'h37, 32'h17, 32'h6F};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int unsigned bits(input int unsigned v, input int hi, input int lo);
        return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    function automatic bit ref_legal(input req_t r);
        case (r.cls)
            4'd0:       return !r.alt || (r.f3 inside {3'd0, 3'd5});
            4'd1:       return !r.alt || (r.f3 == 3'd5);
            4'd2:       return !(r.f3 inside {3'd3, 3'd6, 3'd7});
            4'd3:       return r.f3 <= 3'd2;
            4'd4:       return !(r.f3 inside {3'd2, 3'd3}) && !r.imm[0];
            4'd5:       return r.f3 == 3'd0;
            4'd6, 4'd7: return 1'b1;
            4'd8:       return !r.imm[0];
            default:    return 1'b0;
        endcase
    endfunction

    // Reference word built by placing each field at its bit offset arithmetically.
    function automatic logic [31:0] ref_word(input req_t r);
        int unsigned rd, rs1, rs2, f3, imm, f7, opc, w, immf;
        rd  = 32'(r.rd);  rs1 = 32'(r.rs1); rs2 = 32'(r.rs2);
        f3  = 32'(r.f3);  imm = r.imm;      f7  = r.alt ? 32'd32 : 32'd0;
        opc = (r.cls <= 4'd8) ? OPC[r.cls] : 32'd0;
        case (r.cls)
            4'd0: w = opc | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
            4'd1: begin
                immf = (f3 == 1 || f3 == 5) ? ((f7 << 5) | bits(imm, 4, 0)) : bits(imm, 11, 0);
                w = opc | (rd << 7) | (f3 << 12) | (rs1 << 15) | (immf << 20);
            end
            4'd2: w = opc | (rd << 7) | (f3 << 12) | (rs1 << 15) | (bits(imm, 11, 0) << 20);
            4'd3: w = opc | (bits(imm, 4, 0) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                      | (bits(imm, 11, 5) << 25);
            4'd4: w = opc | (bits(imm, 11, 11) << 7) | (bits(imm, 4, 1) << 8) | (f3 << 12)
                      | (rs1 << 15) | (rs2 << 20) | (bits(imm, 10, 5) << 25) | (bits(imm, 12, 12) << 31);
            4'd5: w = opc | (rd << 7) | (rs1 << 15) | (bits(imm, 11, 0) << 20);
            4'd6, 4'd7: w = opc | (rd << 7) | (imm & 32'hFFFF_F000);
            4'd8: w = opc | (rd << 7) | (bits(imm, 19, 12) << 12) | (bits(imm, 11, 11) << 20)
                      | (bits(imm, 10, 1) << 21) | (bits(imm, 20, 20) << 31);
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    function automatic req_t mk(input int cls, input int f3, input int alt, input int rd,
                                input int rs1, input int rs2, input logic [31:0] imm);
        req_t r;
        r.cls = 4'(cls); r.f3 = 3'(f3); r.alt = 1'(alt);
        r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = imm;
        return r;
    endfunction

    function automatic req_t rand_req();
        return mk(int'($urandom_range(0, 10)), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 32'($urandom));
    endfunction

    task automatic model_accept(input req_t r);
        if (ref_legal(r)) begin
            exp_q.push_back({ref_word(r), BASE + 32'(widx * 4)});
            widx++;
        end else begin
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive(input req_t r);
        req_class = r.cls; req_funct3 = r.f3; req_alt = r.alt;
        req_rd = r.rd; req_rs1 = r.rs1; req_rs2 = r.rs2; req_imm = r.imm;
        req_valid = 1'b1;
    endtask

    task automatic send(input req_t r, input int maxc, output bit acc);
        drive(r);
        acc = 1'b0;
        for (int c = 0; c < maxc && !acc; c++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1'b1;
                model_accept(r);
            end
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        exp_q.delete();
        widx = 0;
        exp_err = 0;
        tick();
        clear = 1'b0;
    endtask

    task automatic drain();
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick();
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every held word must match the scoreboard head; a handshake retires it.
    always @(negedge clk) begin
        if (rst_n && !clear && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h at %h expected no word", out_inst, out_addr);
            end else begin
                chk("out_inst", out_inst, exp_q[0][63:32]);
                chk("out_addr", out_addr, exp_q[0][31:0]);
                if (out_ready) begin
                    seen_inst.push_back(out_inst);
                    seen_addr.push_back(out_addr);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [31:0] stream_k [4] = '{32'h402081B3, 32'h0020A423, 32'hFE208EE3, 32'h008000EF};

    initial begin
        bit acc;
        bit want;
        req_t r;
        rst_n = 1'b1; clear = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
        req_class = 4'd0; req_funct3 = 3'd0; req_alt = 1'b0;
        req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'd0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // addi x1,x0,5 from reset, visible one cycle after accept
        out_ready = 1'b1;
        send(mk(1, 0, 0, 1, 0, 0, 32'd5), 4, acc);
        chk("addi_acc", 32'(acc), 32'd1);
        @(negedge clk);
        chk("addi_latency", 32'(out_valid), 32'd1);
        chk("addi_inst", out_inst, 32'h00500093);
        chk("addi_addr", out_addr, BASE);
        drain();

        // back-to-back stream of four words
        do_clear();
        seen_inst.delete(); seen_addr.delete();
        out_ready = 1'b1;
        send(mk(0, 0, 1, 3, 1, 2, 32'd0), 1, acc);          chk("stream0_acc", 32'(acc), 32'd1);
        send(mk(3, 2, 0, 0, 1, 2, 32'd8), 1, acc);          chk("stream1_acc", 32'(acc), 32'd1);
        send(mk(4, 0, 0, 0, 1, 2, 32'hFFFF_FFFC), 1, acc);  chk("stream2_acc", 32'(acc), 32'd1);
        send(mk(8, 0, 0, 1, 0, 0, 32'd8), 1, acc);          chk("stream3_acc", 32'(acc), 32'd1);
        drain();
        chk("stream_count", 32'(seen_inst.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen_inst.size(); i++) begin
            chk("stream_inst", seen_inst[i], stream_k[i]);
            chk("stream_addr", seen_addr[i], BASE + 32'(i * 4));
        end

        // backpressure: lui held stable, second request waits for out_ready
        do_clear();
        out_ready = 1'b0;
        send(mk(6, 0, 0, 5, 0, 0, 32'h1234_5000), 2, acc);
        chk("lui_acc", 32'(acc), 32'd1);
        r = mk(1, 0, 0, 2, 0, 0, 32'd7);
        drive(r);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_inst", out_inst, 32'h123452B7);
            chk("bp_ready", 32'(req_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept_same_cycle", 32'(req_ready), 32'd1);
        if (req_ready) model_accept(r);
        tick();
        req_valid = 1'b0;
        drain();

        // illegal requests are consumed silently and counted
        do_clear();
        out_ready = 1'b1;
        send(mk(5, 1, 0, 1, 2, 0, 32'd0), 2, acc);  chk("ill_jalr_acc", 32'(acc), 32'd1);
        send(mk(4, 0, 0, 0, 1, 2, 32'd3), 2, acc);  chk("ill_br_acc", 32'(acc), 32'd1);
        @(negedge clk);
        chk("ill_no_out", 32'(out_valid), 32'd0);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_err_cnt", 32'(err_cnt), 32'd2);
        tick();
        send(mk(2, 2, 0, 4, 3, 0, 32'hFFFF_FFF0), 2, acc);
        chk("ill_then_legal_acc", 32'(acc), 32'd1);
        drain();

        // full after DEPTH words, clear restarts at BASE
        do_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            want = (widx < DEPTH);
            send(mk(1, 0, 0, i + 1, 0, 0, 32'(i)), want ? 4 : 3, acc);
            chk("full_acc", 32'(acc), 32'(want));
        end
        drain();
        @(negedge clk);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_ready", 32'(req_ready), 32'd0);
        tick();
        do_clear();
        @(negedge clk);
        chk("clear_full", 32'(full), 32'd0);
        chk("clear_valid", 32'(out_valid), 32'd0);
        tick();
        send(mk(7, 0, 0, 9, 0, 0, 32'hABCD_E000), 2, acc);
        chk("after_clear_acc", 32'(acc), 32'd1);
        drain();

        // err_cnt saturation
        do_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 258; i++) send(mk(9 + (i % 7), 0, 0, 0, 0, 0, 32'd0), 2, acc);
        @(negedge clk);
        chk("sat_err_cnt", 32'(err_cnt), 32'(exp_err));
        tick();
        do_clear();
        @(negedge clk);
        chk("clear_err", 32'(err), 32'd0);
        chk("clear_err_cnt", 32'(err_cnt), 32'd0);
        tick();

        // randomized rounds with random backpressure
        for (int round = 0; round < 25; round++) begin
            do_clear();
            rand_rdy = 1'b1;
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                want = (widx < DEPTH);
                send(rand_req(), want ? 40 : 3, acc);
                chk("rand_acc", 32'(acc), 32'(want));
            end
            drain();
            @(negedge clk);
            chk("rand_err_cnt", 32'(err_cnt), 32'(exp_err));
            chk("rand_err", 32'(err), 32'(exp_err != 0));
            chk("rand_full", 32'(full), 32'(widx == DEPTH));
            tick();
        end

        // asynchronous reset while a word is held
        do_clear();
        out_ready = 1'b0;
        send(mk(1, 0, 0, 1, 0, 0, 32'd1), 2, acc);
        send(mk(1, 0, 0, 2, 0, 0, 32'd2), 1, acc);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_addr", out_addr, BASE);
        exp_q.delete();
        widx = 0;
        exp_err = 0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        send(mk(0, 5, 1, 6, 7, 8, 32'd0), 2, acc);
        chk("post_rst_acc", 32'(acc), 32'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
